hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Pipeline hazard/stall controller for the 5-stage MIPS core. It generates the
//  bubble input of the pipelined controller, plus the PC/IF-ID write enables and
//  the PC source select. Inspects the ID-stage instruction and the ID/EX load; an
//  FSM handles load-use stalls, jump squash, and branches resolved in EX.
// PARAMETERS
//  REG_W     5   register-specifier width (rs/rt fields)
// PORTS
//  CLK         in   1      clock; all state updates on rising edge
//  Reset_L     in   1      synchronous reset, active low
//  ID_Opcode   in   6      opcode of instruction in IF/ID
//  ID_Function in   6      funct of instruction in IF/ID
//  ID_Rs       in   REG_W  rs field of IF/ID instruction
//  ID_Rt       in   REG_W  rt field of IF/ID instruction
//  EX_MemRead  in   1      ID/EX MemRead (load currently in EX)
//  EX_Rt       in   REG_W  ID/EX rt (load destination)
//  EX_ALUZero  in   1      ALU zero flag of instruction in EX
//  bubble      out  1      to controller: force all control outputs to 0
//  PCWrite     out  1      PC register write enable
//  IFWrite     out  1      IF/ID register write enable
//  addrSel     out  2      PC source: 00 PC+4, 01 jump target, 10 branch target
// BEHAVIOUR
//  One clock domain; synchronous, active-low reset on Reset_L.
//  Decode (combinational, from ID_Opcode/ID_Function):
//   isJ = op 000010; isBEQ = op 000100.
//   usesRs = 0 for J, LUI, R-type funct 000000/000010/000011 (SLL/SRL/SRA); else 1.
//   usesRt = 1 for R-type, BEQ, SW; else 0.
//   Unknown opcode: usesRs=usesRt=1, isJ=isBEQ=0.
//  loadUse = EX_MemRead & EX_Rt!=0 & ((usesRs & EX_Rt==ID_Rs) | (usesRt & EX_Rt==ID_Rt)).
//  States: NOHAZ, JUMP, BR_EX, BR_TAKEN. Outputs are Mealy (state + inputs).
//  NOHAZ:
//   loadUse (highest priority): bubble=1 PCWrite=0 IFWrite=0 addrSel=00; stay.
//   else isJ: bubble=0 PCWrite=1 IFWrite=0 addrSel=01; -> JUMP.
//   else isBEQ: bubble=0 PCWrite=0 IFWrite=0 addrSel=00; -> BR_EX.
//   else: bubble=0 PCWrite=1 IFWrite=1 addrSel=00; stay.
//  JUMP: squashes the stale jump held in IF/ID.
//   bubble=1 PCWrite=1 IFWrite=1 addrSel=00; -> NOHAZ.
//  BR_EX: branch is in EX; duplicate in IF/ID is squashed.
//   EX_ALUZero=1: bubble=1 PCWrite=1 IFWrite=0 addrSel=10; -> BR_TAKEN.
//   EX_ALUZero=0: bubble=1 PCWrite=1 IFWrite=1 addrSel=00; -> NOHAZ.
//  BR_TAKEN: bubble=1 PCWrite=1 IFWrite=1 addrSel=00; -> NOHAZ (IF/ID gets target).
//  Inputs ignored in JUMP/BR_TAKEN; only EX_ALUZero is used in BR_EX.
//  Penalties: load-use 1 cycle; J 1 cycle; BEQ not-taken 1 cycle, taken 2 cycles.
//  Reset:
//   While Reset_L=0, outputs forced to bubble=1 PCWrite=0 IFWrite=0 addrSel=00.
//   The next rising edge loads NOHAZ, including mid-branch or mid-jump.
//  Reset dominates all inputs. No stall is generated for rs/rt = $0.
//  Simultaneous load-use and BEQ/J in ID: the load-use stall is taken first. The
//   BEQ/J is re-evaluated next cycle, when EX_MemRead=0 because of the bubble.
// TESTING
//  Reset_L=0 for 2 clks with arbitrary inputs -> bubble=1,PCWrite=0,IFWrite=0,addrSel=00; state NOHAZ after release.
//  EX_MemRead=1,EX_Rt=8; ID ADD rs=8 -> one cycle bubble=1,PCWrite=0,IFWrite=0; next cycle (EX_MemRead=0) normal flow.
//  EX_MemRead=1,EX_Rt=0 or ID LUI rt=8,EX_Rt=8 -> no stall (bubble=0,PCWrite=1,IFWrite=1).
//  ID J -> addrSel=01,PCWrite=1,IFWrite=0; next cycle bubble=1,IFWrite=1,addrSel=00; then NOHAZ.
//  ID BEQ, next cycle EX_ALUZero=1 -> cycles: PCWrite=0; addrSel=10+bubble; bubble+IFWrite=1; NOHAZ.
//  ID BEQ, next cycle EX_ALUZero=0 -> 1 stall cycle; then bubble=1,IFWrite=1,addrSel=00; then NOHAZ.
//  Reset_L=0 while in BR_EX -> outputs forced to reset values; after release, NOHAZ and no branch redirect.

Source files
------------

// File: rtl/hazard_unit.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use stalls, jump squash,
// and branches resolved in EX. Outputs are Mealy (state + ID/EX inputs).
module hazard_unit #(
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic [5:0]       ID_Opcode,
  input  logic [5:0]       ID_Function,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_Rt,
  input  logic             EX_ALUZero,
  output logic             bubble,
  output logic             PCWrite,
  output logic             IFWrite,
  output logic [1:0]       addrSel
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] SEL_PC4 = 2'b00;
  localparam logic [1:0] SEL_JMP = 2'b01;
  localparam logic [1:0] SEL_BR  = 2'b10;

  typedef enum logic [1:0] {NOHAZ, JUMP, BR_EX, BR_TAKEN} state_t;

  typedef struct packed {
    logic       bubble;
    logic       pcwrite;
    logic       ifwrite;
    logic [1:0] addrsel;
  } ctl_t;

  localparam ctl_t CTL_RESET = '{bubble: 1'b1, pcwrite: 1'b0, ifwrite: 1'b0, addrsel: SEL_PC4};
  localparam ctl_t CTL_RUN   = '{bubble: 1'b0, pcwrite: 1'b1, ifwrite: 1'b1, addrsel: SEL_PC4};
  localparam ctl_t CTL_SQSH  = '{bubble: 1'b1, pcwrite: 1'b1, ifwrite: 1'b1, addrsel: SEL_PC4};

  state_t state, state_nxt;
  ctl_t   ctl;
  logic   is_j, is_beq, uses_rs, uses_rt, load_use;

  // Operand usage decode; unrecognised opcodes are treated conservatively as reading both.
  always_comb begin
    is_j    = 1'b0;
    is_beq  = 1'b0;
    uses_rs = 1'b1;
    uses_rt = 1'b1;
    unique case (ID_Opcode)
      OP_RTYPE: begin
        uses_rt = 1'b1;
        uses_rs = !(ID_Function inside {6'b000000, 6'b000010, 6'b000011});
      end
      OP_J: begin
        is_j    = 1'b1;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
      end
      OP_BEQ: begin
        is_beq  = 1'b1;
        uses_rt = 1'b1;
      end
      OP_SW:  uses_rt = 1'b1;
      OP_LUI: begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LW:
        uses_rt = 1'b0;
      default: ;
    endcase
  end

  assign load_use = EX_MemRead && (EX_Rt != '0) &&
                    ((uses_rs && (EX_Rt == ID_Rs)) || (uses_rt && (EX_Rt == ID_Rt)));

  always_comb begin
    ctl       = CTL_RUN;
    state_nxt = state;
    if (!Reset_L) begin
      ctl       = CTL_RESET;
      state_nxt = NOHAZ;
    end else begin
      unique case (state)
        NOHAZ: begin
          if (load_use) begin
            ctl = CTL_RESET;
          end else if (is_j) begin
            ctl       = '{bubble: 1'b0, pcwrite: 1'b1, ifwrite: 1'b0, addrsel: SEL_JMP};
            state_nxt = JUMP;
          end else if (is_beq) begin
            ctl       = '{bubble: 1'b0, pcwrite: 1'b0, ifwrite: 1'b0, addrsel: SEL_PC4};
            state_nxt = BR_EX;
          end
        end
        JUMP: begin
          ctl       = CTL_SQSH;
          state_nxt = NOHAZ;
        end
        BR_EX: begin
          if (EX_ALUZero) begin
            ctl       = '{bubble: 1'b1, pcwrite: 1'b1, ifwrite: 1'b0, addrsel: SEL_BR};
            state_nxt = BR_TAKEN;
          end else begin
            ctl       = CTL_SQSH;
            state_nxt = NOHAZ;
          end
        end
        BR_TAKEN: begin
          ctl       = CTL_SQSH;
          state_nxt = NOHAZ;
        end
        default: begin
          ctl       = CTL_RESET;
          state_nxt = NOHAZ;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) state <= state_nxt;

  assign bubble  = ctl.bubble;
  assign PCWrite = ctl.pcwrite;
  assign IFWrite = ctl.ifwrite;
  assign addrSel = ctl.addrsel;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit; outputs packed as {bubble,PCWrite,IFWrite,addrSel}.
module tb_hazard_unit;
  logic       CLK = 1'b0;
  logic       Reset_L;
  logic [5:0] ID_Opcode, ID_Function;
  logic [4:0] ID_Rs, ID_Rt, EX_Rt;
  logic       EX_MemRead, EX_ALUZero;
  logic       bubble, PCWrite, IFWrite;
  logic [1:0] addrSel;
  int checks = 0;
  int errors = 0;

  localparam logic [4:0] O_RST  = 5'b1_0_0_00;
  localparam logic [4:0] O_RUN  = 5'b0_1_1_00;
  localparam logic [4:0] O_JMP  = 5'b0_1_0_01;
  localparam logic [4:0] O_SQSH = 5'b1_1_1_00;
  localparam logic [4:0] O_BEQ  = 5'b0_0_0_00;
  localparam logic [4:0] O_BRT  = 5'b1_1_0_10;

  hazard_unit #(.REG_W(5)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .ID_Opcode(ID_Opcode), .ID_Function(ID_Function),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
    .EX_ALUZero(EX_ALUZero), .bubble(bubble), .PCWrite(PCWrite), .IFWrite(IFWrite),
    .addrSel(addrSel)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs at negedge, check mid-low-phase, then cross one posedge.
  task automatic cyc(input string tag, input logic rl, input logic [5:0] op, input logic [5:0] fn,
                     input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                     input logic [4:0] ert, input logic z, input logic [4:0] exp);
    Reset_L = rl; ID_Opcode = op; ID_Function = fn; ID_Rs = rs; ID_Rt = rt;
    EX_MemRead = mr; EX_Rt = ert; EX_ALUZero = z;
    #1;
    chk(tag, {bubble, PCWrite, IFWrite, addrSel}, exp);
    @(negedge CLK);
  endtask

  localparam logic [5:0] R = 6'b000000, J = 6'b000010, BEQ = 6'b000100;
  localparam logic [5:0] LUI = 6'b001111, SW = 6'b101011, LW = 6'b100011, UNK = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SLL = 6'b000000;

  initial begin
    @(negedge CLK);
    cyc("rst0", 0, J,   0,     8, 8, 1, 8, 1, O_RST);
    cyc("rst1", 0, BEQ, 0,     8, 8, 1, 8, 1, O_RST);
    cyc("run",  1, R,   F_ADD, 1, 2, 0, 0, 0, O_RUN);
    // load-use on rs, then released by the bubble
    cyc("lu_add",   1, R,   F_ADD, 8, 2, 1, 8, 0, O_RST);
    cyc("lu_after", 1, R,   F_ADD, 8, 2, 0, 8, 0, O_RUN);
    cyc("zero_reg", 1, R,   F_ADD, 0, 0, 1, 0, 0, O_RUN);
    cyc("lui_norl", 1, LUI, 0,     8, 8, 1, 8, 0, O_RUN);
    cyc("sw_rt",    1, SW,  0,     3, 8, 1, 8, 0, O_RST);
    cyc("sll_rs",   1, R,   F_SLL, 8, 2, 1, 8, 0, O_RUN);
    cyc("sll_rt",   1, R,   F_SLL, 2, 8, 1, 8, 0, O_RST);
    cyc("lw_rt",    1, LW,  0,     3, 8, 1, 8, 0, O_RUN);
    cyc("lw_rs",    1, LW,  0,     8, 3, 1, 8, 0, O_RST);
    cyc("unk_rt",   1, UNK, 0,     3, 8, 1, 8, 0, O_RST);
    // jump: redirect, squash, resume
    cyc("j0", 1, J, 0,     0, 0, 0, 0, 0, O_JMP);
    cyc("j1", 1, J, 0,     8, 8, 1, 8, 0, O_SQSH);
    cyc("j2", 1, R, F_ADD, 1, 2, 0, 0, 0, O_RUN);
    // load-use beats BEQ, then taken branch; BR_EX ignores MemRead
    cyc("beq_lu", 1, BEQ, 0,     8, 2, 1, 8, 0, O_RST);
    cyc("beq_id", 1, BEQ, 0,     8, 2, 0, 8, 0, O_BEQ);
    cyc("beq_tk", 1, R,   F_ADD, 8, 8, 1, 8, 1, O_BRT);
    cyc("br_tgt", 1, BEQ, 0,     8, 8, 1, 8, 1, O_SQSH);
    cyc("br_res", 1, R,   F_ADD, 1, 2, 0, 0, 0, O_RUN);
    // not-taken branch
    cyc("nt_id",  1, BEQ, 0,     1, 2, 0, 0, 0, O_BEQ);
    cyc("nt_ex",  1, J,   0,     0, 0, 0, 0, 0, O_SQSH);
    cyc("nt_res", 1, R,   F_ADD, 1, 2, 0, 0, 0, O_RUN);
    // reset during BR_EX: no redirect afterwards
    cyc("rb_id",  1, BEQ, 0,     1, 2, 0, 0, 0, O_BEQ);
    cyc("rb_rst", 0, BEQ, 0,     1, 2, 0, 0, 1, O_RST);
    cyc("rb_rel", 1, R,   F_ADD, 1, 2, 0, 0, 1, O_RUN);
    // reset during JUMP
    cyc("rj_id",  1, J,   0,     0, 0, 0, 0, 0, O_JMP);
    cyc("rj_rst", 0, J,   0,     0, 0, 0, 0, 0, O_RST);
    cyc("rj_rel", 1, R,   F_ADD, 1, 2, 0, 0, 0, O_RUN);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
